// File: rtl/gpr_loader.sv
// Host-to-core GPR image loader: stalls the core, waits for drain, streams NREG words into the regfile.
// Optional image checksum check enabled by defining GPR_LOADER_CHECKSUM_EN.
module gpr_loader #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_start,
  input  logic [XLEN-1:0] exp_sum,
  input  logic            abort,
  input  logic            core_idle,
  output logic            core_stall,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  output logic            rf_wen,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_LOAD,
    S_DONE
  } state_e;

  localparam logic [AW-1:0] LastIdx = AW'(NREG - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_DRAIN;
          idx_d   = '0;
        end
      end
      S_DRAIN: begin
        if (abort)          state_d = S_IDLE;
        else if (core_idle) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          // idx never reaches NREG here: the last handshake moves straight to DONE
          in_ready = 1'b1;
          if (in_valid) begin
            wen_d   = (idx_q != '0);
            waddr_d = idx_q;
            wdata_d = in_data;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LastIdx) state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign core_stall = (state_q != S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign rf_wen     = wen_q;
  assign rf_waddr   = waddr_q;
  assign rf_wdata   = wdata_q;

`ifdef GPR_LOADER_CHECKSUM_EN
  logic [XLEN-1:0] sum_q, sum_d;
  logic [XLEN-1:0] exp_q, exp_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      sum_q <= '0;
      exp_q <= '0;
    end else begin
      sum_q <= sum_d;
      exp_q <= exp_d;
    end
  end

  always_comb begin
    sum_d = sum_q;
    exp_d = exp_q;
    if (state_q == S_IDLE && load_start) begin
      sum_d = '0;
      exp_d = exp_sum;
    end else if (in_valid && in_ready) begin
      sum_d = sum_q + in_data;
    end
  end

  assign err = done && (sum_q != exp_q);
`else
  logic unused_exp_sum;
  assign unused_exp_sum = ^exp_sum;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gpr_loader.sv
// Directed bench for gpr_loader: full loads, gapped stream, abort, restart, checksum, mid-load reset.
module tb_gpr_loader;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;
`ifdef GPR_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            load_start = 1'b0;
  logic [XLEN-1:0] exp_sum = '0;
  logic            abort = 1'b0;
  logic            core_idle = 1'b0;
  logic            core_stall;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_data = '0;
  logic            rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            busy, done, err;

  always #5 clock = ~clock;

  gpr_loader #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clock(clock), .reset(reset), .load_start(load_start), .exp_sum(exp_sum),
    .abort(abort), .core_idle(core_idle), .core_stall(core_stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int failures = 0;

  // Observer: each handshake must produce exactly one write (none for x0) one cycle later.
  int n_hs = 0, n_wr = 0, n_done = 0, n_err = 0, n_bad = 0;
  int tb_idx = 0;
  int p_idx = 0;
  bit p_hs = 1'b0;
  logic [XLEN-1:0] p_data = '0;

  always @(negedge clock) begin
    if (rf_wen !== (p_hs && p_idx != 0)) n_bad++;
    else if (rf_wen === 1'b1 && (rf_waddr !== AW'(p_idx) || rf_wdata !== p_data)) n_bad++;
    if (rf_wen === 1'b1) n_wr++;
    if (done === 1'b1) n_done++;
    if (err === 1'b1) begin
      n_err++;
      if (done !== 1'b1) n_bad++;
    end
    p_hs   = !reset && in_valid && (in_ready === 1'b1);
    p_idx  = tb_idx;
    p_data = in_data;
    if (p_hs) begin
      tb_idx++;
      n_hs++;
    end
    if (reset || (load_start && busy === 1'b0)) tb_idx = 0;
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic start_load(input logic [XLEN-1:0] es);
    tick();
    exp_sum = es;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(input int i, input int mode, input bit gap);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = (mode == 1) ? 64'd1 : 64'(i + 'h100);
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout idx=%0d got in_ready=0 required 1", i);
    end
    tick();
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
  endtask

  task automatic run_load(input int mode, input logic [XLEN-1:0] es);
    start_load(es);
    core_idle = 1'b1;
    for (int i = 0; i < NREG; i++) send(i, mode, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({core_stall, in_ready, rf_wen, busy, done, err} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000000", {core_stall, in_ready, rf_wen, busy, done, err});
    end
    checks++;
    if (rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_waddr got=%0h exp=0", rf_waddr); end
    checks++;
    if (rf_wdata !== 64'd0) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", rf_wdata); end
  endtask

  task automatic test_full_load();
    int b_wr, b_done, b_bad;
    b_wr = n_wr; b_done = n_done; b_bad = n_bad;
    core_idle = 1'b0;
    start_load('0);
    @(negedge clock);
    checks++;
    if ({core_stall, in_ready, busy} !== 3'b101) begin
      failures++; $display("FAIL drain_ctrl got=%b exp=101", {core_stall, in_ready, busy});
    end
    tick(); tick(); tick();
    core_idle = 1'b1;
    send(0, 0, 1'b0);
    in_data = 64'h101;
    @(negedge clock);
    checks++;
    if ({rf_wen, in_ready} !== 2'b01) begin
      failures++; $display("FAIL idx0_nowrite got=%b exp=01", {rf_wen, in_ready});
    end
    tick();
    for (int i = 2; i < NREG; i++) send(i, 0, 1'b0);
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({done, rf_wen, core_stall, in_ready} !== 4'b1110) begin
      failures++; $display("FAIL done_cycle got=%b exp=1110", {done, rf_wen, core_stall, in_ready});
    end
    checks++;
    if (rf_waddr !== 5'd31) begin failures++; $display("FAIL last_waddr got=%0d exp=31", rf_waddr); end
    checks++;
    if (rf_wdata !== 64'h11F) begin failures++; $display("FAIL last_wdata got=%0h exp=11f", rf_wdata); end
    tick();
    @(negedge clock);
    checks++;
    if ({core_stall, busy, done} !== 3'b000) begin
      failures++; $display("FAIL stall_drop got=%b exp=000", {core_stall, busy, done});
    end
    tick();
    checks++;
    if (n_wr - b_wr !== 31) begin failures++; $display("FAIL full_writes got=%0d exp=31", n_wr - b_wr); end
    checks++;
    if (n_done - b_done !== 1) begin failures++; $display("FAIL full_done got=%0d exp=1", n_done - b_done); end
    checks++;
    if (n_bad - b_bad !== 0) begin failures++; $display("FAIL full_order got=%0d exp=0", n_bad - b_bad); end
  endtask

  task automatic test_gap();
    int b_wr, b_done, b_bad, b_hs;
    b_wr = n_wr; b_done = n_done; b_bad = n_bad; b_hs = n_hs;
    start_load('0);
    for (int i = 0; i < NREG; i++) send(i, 0, 1'b1);
    tick(); tick();
    checks++;
    if (n_hs - b_hs !== 32) begin failures++; $display("FAIL gap_hs got=%0d exp=32", n_hs - b_hs); end
    checks++;
    if (n_wr - b_wr !== 31) begin failures++; $display("FAIL gap_writes got=%0d exp=31", n_wr - b_wr); end
    checks++;
    if (n_done - b_done !== 1) begin failures++; $display("FAIL gap_done got=%0d exp=1", n_done - b_done); end
    checks++;
    if (n_bad - b_bad !== 0) begin failures++; $display("FAIL gap_timing got=%0d exp=0", n_bad - b_bad); end
  endtask

  task automatic test_abort();
    int b_wr, b_done, b_bad;
    b_wr = n_wr; b_done = n_done; b_bad = n_bad;
    start_load('0);
    for (int i = 0; i < 10; i++) send(i, 0, 1'b0);
    in_data = 64'h10A;
    abort = 1'b1;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL abort_ready got=%b exp=0", in_ready); end
    checks++;
    if ({rf_wen, rf_waddr} !== {1'b1, 5'd9}) begin
      failures++; $display("FAIL abort_lastwr got=%b/%0d exp=1/9", rf_wen, rf_waddr);
    end
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, core_stall, rf_wen} !== 3'b000) begin
      failures++; $display("FAIL abort_idle got=%b exp=000", {busy, core_stall, rf_wen});
    end
    tick(); tick();
    checks++;
    if (n_wr - b_wr !== 9) begin failures++; $display("FAIL abort_writes got=%0d exp=9", n_wr - b_wr); end
    checks++;
    if (n_done - b_done !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", n_done - b_done); end
  endtask

  task automatic test_restart();
    int b_wr, b_done, b_bad, b_hs;
    b_wr = n_wr; b_done = n_done; b_bad = n_bad; b_hs = n_hs;
    start_load('0);
    for (int i = 0; i < NREG; i++) begin
      load_start = (i == 5);
      send(i, 0, 1'b0);
    end
    load_start = 1'b0;
    in_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (n_hs - b_hs !== 32) begin failures++; $display("FAIL restart_hs got=%0d exp=32", n_hs - b_hs); end
    checks++;
    if (n_wr - b_wr !== 31) begin failures++; $display("FAIL restart_writes got=%0d exp=31", n_wr - b_wr); end
    checks++;
    if (n_done - b_done !== 1) begin failures++; $display("FAIL restart_done got=%0d exp=1", n_done - b_done); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL restart_busy got=%b exp=0", busy); end
  endtask

  task automatic test_checksum();
    int b_err, b_bad;
    b_err = n_err; b_bad = n_bad;
    run_load(1, 64'd32);
    @(negedge clock);
    checks++;
    if ({done, err} !== 2'b10) begin failures++; $display("FAIL ck_match got=%b exp=10", {done, err}); end
    tick(); tick();
    run_load(1, 64'd31);
    @(negedge clock);
    checks++;
    if ({done, err} !== {1'b1, CK}) begin
      failures++; $display("FAIL ck_mismatch got=%b exp=%b", {done, err}, {1'b1, CK});
    end
    tick(); tick();
    checks++;
    if (n_err - b_err !== int'(CK)) begin
      failures++; $display("FAIL ck_errcount got=%0d exp=%0d", n_err - b_err, int'(CK));
    end
    checks++;
    if (n_bad - b_bad !== 0) begin failures++; $display("FAIL ck_writes got=%0d exp=0", n_bad - b_bad); end
  endtask

  task automatic test_reset_mid();
    int b_wr, b_done, b_bad;
    start_load('0);
    for (int i = 0; i < 20; i++) send(i, 0, 1'b0);
    in_data = 64'h114;
    reset = 1'b1;
    tick();
    @(negedge clock);
    checks++;
    if ({core_stall, in_ready, rf_wen, busy, done, err} !== 6'b0) begin
      failures++; $display("FAIL midrst_ctrl got=%b exp=000000", {core_stall, in_ready, rf_wen, busy, done, err});
    end
    checks++;
    if ({rf_waddr, rf_wdata} !== '0) begin
      failures++; $display("FAIL midrst_wport got=%0h/%0h exp=0/0", rf_waddr, rf_wdata);
    end
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    b_wr = n_wr; b_done = n_done; b_bad = n_bad;
    run_load(0, '0);
    tick(); tick(); tick();
    checks++;
    if (n_wr - b_wr !== 31) begin failures++; $display("FAIL midrst_writes got=%0d exp=31", n_wr - b_wr); end
    checks++;
    if (n_done - b_done !== 1) begin failures++; $display("FAIL midrst_done got=%0d exp=1", n_done - b_done); end
    checks++;
    if (n_bad - b_bad !== 0) begin failures++; $display("FAIL midrst_order got=%0d exp=0", n_bad - b_bad); end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_gap();
    test_abort();
    test_restart();
    test_checksum();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
